// File: rtl/sdpram_bist_master.sv
// Built-in self-test initiator for a simple dual-port RAM: fills every word with a
// selectable pattern, reads it all back and reports mismatches.
module sdpram_bist_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int unsigned RD_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [1:0]            pattern_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ADDR_WIDTH:0]   err_count_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o,
    output logic                  wena_o,
    output logic [ADDR_WIDTH-1:0] addra_o,
    output logic [DATA_WIDTH-1:0] dina_o,
    output logic                  renb_o,
    output logic [ADDR_WIDTH-1:0] addrb_o,
    input  logic [DATA_WIDTH-1:0] doutb_i
);

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam int unsigned DrainW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [DrainW-1:0] LastDrain = DrainW'(RD_LATENCY - 1);

    typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_e;

    state_e                  state_q;
    logic [1:0]              pat_q;
    logic [DATA_WIDTH-1:0]   seed_q;
    logic [DrainW-1:0]       drain_cnt_q;
    logic                    busy_q, done_q, pass_q, wena_q, renb_q;
    logic [ADDR_WIDTH:0]     err_count_q, err_count_d;
    logic [ADDR_WIDTH-1:0]   first_err_addr_q, first_err_addr_d;
    logic [ADDR_WIDTH-1:0]   addra_q, addrb_q;
    logic [DATA_WIDTH-1:0]   dina_q;

    // Expected-address pipeline, aligned with the RAM read latency.
    logic                    exp_vld_q  [RD_LATENCY];
    logic [ADDR_WIDTH-1:0]   exp_addr_q [RD_LATENCY];

    logic                    head_vld;
    logic [ADDR_WIDTH-1:0]   head_addr;
    logic                    mismatch;

    function automatic logic [DATA_WIDTH-1:0] pat_word(input logic [1:0] p,
                                                       input logic [DATA_WIDTH-1:0] s,
                                                       input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] ext;
        ext = DATA_WIDTH'(a);
        unique case (p)
            2'd0:    return ext;
            2'd1:    return ~ext;
            2'd2:    return s;
            default: return ext ^ s;
        endcase
    endfunction

    always_comb begin
        head_vld         = exp_vld_q[RD_LATENCY-1];
        head_addr        = exp_addr_q[RD_LATENCY-1];
        mismatch         = head_vld && (doutb_i != pat_word(pat_q, seed_q, head_addr));
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        if (mismatch) begin
            if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
            if (err_count_q == '0) first_err_addr_d = head_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                exp_vld_q[i]  <= 1'b0;
                exp_addr_q[i] <= '0;
            end
        end else begin
            for (int i = RD_LATENCY - 1; i > 0; i--) begin
                exp_vld_q[i]  <= exp_vld_q[i-1];
                exp_addr_q[i] <= exp_addr_q[i-1];
            end
            exp_vld_q[0]  <= (state_q == StRead);
            exp_addr_q[0] <= addrb_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StIdle;
            pat_q            <= '0;
            seed_q           <= '0;
            drain_cnt_q      <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
            wena_q           <= 1'b0;
            addra_q          <= '0;
            dina_q           <= '0;
            renb_q           <= 1'b0;
            addrb_q          <= '0;
        end else begin
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        pat_q            <= pattern_i;
                        seed_q           <= seed_i;
                        err_count_q      <= '0;
                        first_err_addr_q <= '0;
                        done_q           <= 1'b0;
                        pass_q           <= 1'b0;
                        busy_q           <= 1'b1;
                        wena_q           <= 1'b1;
                        addra_q          <= '0;
                        dina_q           <= pat_word(pattern_i, seed_i, '0);
                        state_q          <= StWrite;
                    end
                end
                StWrite: begin
                    if (addra_q == LastAddr) begin
                        wena_q  <= 1'b0;
                        renb_q  <= 1'b1;
                        addrb_q <= '0;
                        state_q <= StRead;
                    end else begin
                        addra_q <= addra_q + 1'b1;
                        dina_q  <= pat_word(pat_q, seed_q, addra_q + 1'b1);
                    end
                end
                StRead: begin
                    if (addrb_q == LastAddr) begin
                        drain_cnt_q <= '0;
                        state_q     <= StDrain;
                    end else begin
                        addrb_q <= addrb_q + 1'b1;
                    end
                end
                StDrain: begin
                    // The final compare lands on this edge, so pass uses the updated count.
                    if (drain_cnt_q == LastDrain) begin
                        renb_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_count_d == '0);
                        state_q <= StDone;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign err_count_o      = err_count_q;
    assign first_err_addr_o = first_err_addr_q;
    assign wena_o           = wena_q;
    assign addra_o          = addra_q;
    assign dina_o           = dina_q;
    assign renb_o           = renb_q;
    assign addrb_o          = addrb_q;

endmodule

// File: tb/tb_sdpram_bist_master.sv
// Bench for sdpram_bist_master: two configurations, each beside a behavioural RAM with
// optional read faults, checked against a pattern/fault model.
module tb_sdpram_bist_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_r, sel;
    logic [1:0]  pattern;
    logic [31:0] seed;
    int          fault_mode;
    int          total = 0;
    int          bad = 0;

    logic        start_a, busy_a, done_a, pass_a, wena_a, renb_a;
    logic [4:0]  err_a;
    logic [3:0]  ferr_a, addra_a, addrb_a;
    logic [31:0] dina_a, doutb_a;
    logic        start_b, busy_b, done_b, pass_b, wena_b, renb_b;
    logic [4:0]  err_b;
    logic [3:0]  ferr_b, addra_b, addrb_b;
    logic [31:0] dina_b, doutb_b;

    always #5 clk = ~clk;

    assign start_a = start_r & ~sel;
    assign start_b = start_r & sel;

    sdpram_bist_master #(.DATA_WIDTH(32), .MEM_DEPTH(16), .RD_LATENCY(3)) u_a (
        .clk(clk), .rst(rst), .start_i(start_a), .pattern_i(pattern), .seed_i(seed),
        .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .err_count_o(err_a),
        .first_err_addr_o(ferr_a), .wena_o(wena_a), .addra_o(addra_a), .dina_o(dina_a),
        .renb_o(renb_a), .addrb_o(addrb_a), .doutb_i(doutb_a)
    );

    sdpram_bist_master #(.DATA_WIDTH(32), .MEM_DEPTH(12), .RD_LATENCY(1)) u_b (
        .clk(clk), .rst(rst), .start_i(start_b), .pattern_i(pattern), .seed_i(seed),
        .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .err_count_o(err_b),
        .first_err_addr_o(ferr_b), .wena_o(wena_b), .addra_o(addra_b), .dina_o(dina_b),
        .renb_o(renb_b), .addrb_o(addrb_b), .doutb_i(doutb_b)
    );

    // RAM read-path fault injection: 1 = bit 0 flipped at addresses 4 and 9, 2 = stuck ones.
    function automatic logic [31:0] ram_rd(input int mode, input int a, input logic [31:0] d);
        if (mode == 1 && (a == 4 || a == 9)) return d ^ 32'd1;
        if (mode == 2) return 32'hFFFF_FFFF;
        return d;
    endfunction

    function automatic logic [31:0] model_word(input logic [1:0] p, input logic [31:0] s,
                                               input int a);
        logic [31:0] av;
        av = 32'(a);
        case (p)
            2'd0:    return av;
            2'd1:    return ~av;
            2'd2:    return s;
            default: return av ^ s;
        endcase
    endfunction

    logic [31:0] mem_a [16];
    logic [31:0] pipe_a [3];
    logic [31:0] mem_b [12];
    logic [31:0] pipe_b;

    always @(posedge clk) begin
        if (wena_a) mem_a[addra_a] <= dina_a;
        if (renb_a) begin
            pipe_a[2] <= pipe_a[1];
            pipe_a[1] <= pipe_a[0];
            pipe_a[0] <= ram_rd(fault_mode, int'(addrb_a), mem_a[addrb_a]);
        end
        if (wena_b) mem_b[addra_b] <= dina_b;
        if (renb_b) pipe_b <= ram_rd(fault_mode, int'(addrb_b), mem_b[addrb_b]);
    end
    assign doutb_a = pipe_a[2];
    assign doutb_b = pipe_b;

    // Traffic trace of whichever DUT is selected.
    int          wq_addr[$];
    logic [31:0] wq_data[$];
    int          rq_addr[$];

    always @(posedge clk) begin
        if (sel ? wena_b : wena_a) begin
            wq_addr.push_back(int'(sel ? addra_b : addra_a));
            wq_data.push_back(sel ? dina_b : dina_a);
        end
        if (sel ? renb_b : renb_a) rq_addr.push_back(int'(sel ? addrb_b : addrb_a));
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic s_dut, input int n, input int lat, input logic [1:0] p,
                       input logic [31:0] s, input int fault, input int stray);
        int cyc, busy_cnt, werr, rerr, exp_err, exp_first;
        logic [31:0] w;
        sel = s_dut;
        fault_mode = fault;
        pattern = p;
        seed = s;
        wq_addr.delete();
        wq_data.delete();
        rq_addr.delete();
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        check("start_clears_done", sel ? done_b : done_a, 0);
        check("start_clears_err", sel ? err_b : err_a, 0);
        check("first_write", {31'd0, sel ? wena_b : wena_a, 28'd0, sel ? addra_b : addra_a},
              {31'd0, 1'b1, 32'd0});
        cyc = 0;
        busy_cnt = 0;
        while (!(sel ? done_b : done_a) && cyc < 200) begin
            if (sel ? busy_b : busy_a) busy_cnt++;
            if (cyc == stray) begin
                start_r = 1'b1;
                pattern = ~p;
                seed = ~s;
            end
            @(negedge clk);
            start_r = 1'b0;
            pattern = p;
            seed = s;
            cyc++;
        end
        check("timeout", sel ? done_b : done_a, 1);
        check("busy_cycles", busy_cnt, 2 * n + lat);

        exp_err = 0;
        exp_first = 0;
        for (int a = 0; a < n; a++) begin
            w = model_word(p, s, a);
            if (ram_rd(fault, a, w) != w) begin
                if (exp_err == 0) exp_first = a;
                exp_err++;
            end
        end
        check("err_count", sel ? err_b : err_a, exp_err);
        check("first_err_addr", sel ? ferr_b : ferr_a, exp_first);
        check("pass", sel ? pass_b : pass_a, exp_err == 0);

        werr = 0;
        for (int i = 0; i < wq_addr.size(); i++)
            if (wq_addr[i] != i || wq_data[i] !== model_word(p, s, i)) werr++;
        check("write_count", wq_addr.size(), n);
        check("write_trace", werr, 0);
        rerr = 0;
        for (int i = 0; i < rq_addr.size(); i++)
            if (rq_addr[i] != ((i < n) ? i : n - 1)) rerr++;
        check("read_count", rq_addr.size(), n + lat);
        check("read_trace", rerr, 0);

        @(negedge clk);
        check("done_held", sel ? done_b : done_a, 1);
        check("idle_after", {sel ? busy_b : busy_a, sel ? renb_b : renb_a,
                             sel ? wena_b : wena_a}, 0);
    endtask

    initial begin
        int hit;
        rst = 1'b1;
        start_r = 1'b0;
        sel = 1'b0;
        pattern = 2'd0;
        seed = 32'd0;
        fault_mode = 0;
        repeat (3) @(negedge clk);
        check("rst_ctrl_a", {busy_a, done_a, pass_a, wena_a, renb_a}, 0);
        check("rst_data_a", {err_a, ferr_a, addra_a, addrb_a, dina_a}, 0);
        check("rst_ctrl_b", {busy_b, done_b, pass_b, wena_b, renb_b}, 0);
        rst = 1'b0;
        @(negedge clk);

        run(1'b0, 16, 3, 2'd0, 32'd0, 0, -1);
        run(1'b0, 16, 3, 2'd3, 32'hA5A5_0000, 0, -1);
        check("dina_addr5", wq_data.size() > 5 ? wq_data[5] : 32'hX, 32'hA5A5_0005);
        run(1'b0, 16, 3, 2'd1, $urandom, 1, -1);
        check("fault_err_count", err_a, 2);
        check("fault_first_addr", ferr_a, 4);
        run(1'b0, 16, 3, 2'($urandom_range(0, 3)), $urandom, 0, 10);
        run(1'b0, 16, 3, 2'($urandom_range(0, 3)), $urandom, 1, 34);

        // Reset in the middle of the read phase.
        pattern = 2'd0;
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        hit = 0;
        for (int c = 0; c < 100 && hit == 0; c++) begin
            if (renb_a && addrb_a == 4'd7) hit = 1;
            else @(negedge clk);
        end
        check("reach_read7", hit, 1);
        rst = 1'b1;
        #1;
        check("midrst_ctrl", {wena_a, renb_a, busy_a, done_a, pass_a}, 0);
        check("midrst_data", {err_a, addra_a, addrb_a}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(1'b0, 16, 3, 2'($urandom_range(0, 3)), $urandom, 0, -1);

        run(1'b1, 12, 1, 2'd2, 32'd0, 0, -1);
        run(1'b1, 12, 1, 2'd2, 32'd0, 2, -1);
        check("stuck_err_count", err_b, 12);
        check("stuck_first_addr", ferr_b, 0);
        run(1'b1, 12, 1, 2'($urandom_range(0, 3)), $urandom, 1, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdpram_bist_master.md
Name: sdpram_bist_master

Overview:
- Initiator for the simple dual-port RAM interface.
- Drives write port A (wena/addra/dina) and read port B (renb/addrb), and consumes read data (doutb).
- Sequence: writes a selectable data pattern to every location, reads every location back, compares against the expected pattern, and reports pass/fail, error count and first failing address.
- Sits beside the RAM as a built-in self-test and traffic source for bring-up and regression.

Parameters:
- DATA_WIDTH, 32, RAM word width.
- MEM_DEPTH, 16, number of RAM words; must be ≥2.
- ADDR_WIDTH, $clog2(MEM_DEPTH), address width.
- RD_LATENCY, 3, cycles from addrb presented with renb=1 to matching doutb; must be ≥1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle request; accepted only in IDLE or DONE.
- pattern  in  2  data pattern, sampled on accepted start: 0=addr, 1=~addr, 2=seed, 3=addr^seed (addr zero-extended to DATA_WIDTH).
- seed  in  DATA_WIDTH  pattern seed, sampled on accepted start.
- busy  out  1  high from the cycle after accepted start through the last DRAIN cycle.
- done  out  1  high in DONE; held until next accepted start.
- pass  out  1  valid while done=1; 1 iff err_count==0.
- err_count  out  ADDR_WIDTH+1  number of mismatching words; saturates at all-ones.
- first_err_addr  out  ADDR_WIDTH  address of first mismatch; 0 if none.
- wena  out  1  RAM write enable.
- addra  out  ADDR_WIDTH  RAM write address.
- dina  out  DATA_WIDTH  RAM write data.
- renb  out  1  RAM read enable.
- addrb  out  ADDR_WIDTH  RAM read address.
- doutb  in  DATA_WIDTH  RAM read data.

Behaviour:
- All outputs are registered.
- Reset values: every output 0; state IDLE; latched pattern and seed = 0.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE / DONE:
  - start=1: latch pattern and seed, clear err_count, first_err_addr and done, then go to WRITE.
  - start=0: remain in the current state.
- WRITE:
  - MEM_DEPTH cycles; wena=1, addra=0..MEM_DEPTH-1 incrementing by 1 per cycle, dina=pattern(addra).
  - After the cycle with addra=MEM_DEPTH-1, go to READ; wena=0 from then on.
- READ:
  - MEM_DEPTH cycles; renb=1, addrb=0..MEM_DEPTH-1.
  - For each cycle k, push (valid=1, addrb) into an RD_LATENCY-deep expected-address shift register.
- DRAIN:
  - RD_LATENCY cycles; renb stays 1, addrb holds MEM_DEPTH-1, shift register pushes valid=0.
  - The RAM pipeline advances only while renb=1, so renb must never drop between READ entry and DRAIN exit.
  - After the last DRAIN cycle: renb=0, busy=0, done=1, pass=(err_count==0); go to DONE.
- Compare:
  - In any cycle where the shift-register head is valid (cycle k+RD_LATENCY for the address issued in cycle k), compare doutb against pattern(head addr).
  - Mismatch: err_count += 1 unless saturated; if this is the first mismatch of the run, first_err_addr = head addr.
  - Exactly MEM_DEPTH compares per run.
- Total run length: 2*MEM_DEPTH + RD_LATENCY busy cycles.
- start while busy: ignored, with no effect on the sequence.
- start in the same cycle done would assert: ignored; done asserts normally.
- Address counters never wrap mid-phase; terminal count is MEM_DEPTH-1, also for non-power-of-2 depths.
- rst asserted mid-run: immediately return to IDLE with all outputs 0. The RAM contents are left as partially written.

Test Plan:
- Reset, pulse start with pattern=0 on a healthy RAM (DEPTH=16, RD_LATENCY=3):
  - Required: 16 writes with addra 0..15 and dina 0..15, then 16 reads.
  - Required: busy high for 35 cycles, then done=1, pass=1, err_count=0, first_err_addr=0.
- pattern=3, seed=32'hA5A5_0000:
  - Required: dina at addr 5 = 32'hA5A5_0005.
  - Required: readback passes, done=1, pass=1.
- pattern=1 with the RAM model forcing bit 0 of doutb inverted for addresses 4 and 9:
  - Required: err_count=2, first_err_addr=4, pass=0.
- Pulse start again at cycle 10 of a run:
  - Required: the run completes unchanged in 35 cycles.
  - Required: a subsequent start from DONE clears err_count and done and reruns.
- Assert rst during READ (addrb=7):
  - Required: wena=renb=busy=done=0 immediately, state IDLE.
  - Required: a new start then runs the full sequence from addr 0.
- DEPTH=12, RD_LATENCY=1, pattern=2, seed=0:
  - Required: addresses 0..11 only, busy for 25 cycles, pass=1.
  - Required: a stuck-at-all-ones RAM gives err_count=12, first_err_addr=0.
